pa_clint_regs_mh: RTL
=====================

# pa_clint_regs_mh

Multi-hart CLINT register file with an internal 64-bit mtime counter. It holds per-hart MSIP and MTIMECMP registers and generates registered per-hart software, timer and external interrupt outputs. It sits between the CLINT bus interface, which supplies decoded read/write strobes plus a word offset, and the cores. It replaces the single-hart variant that depended on an external mtime source.

## Interface
Parameters:
- HART_NUM, 4: number of harts served (1-16).
- TICK_DIV, 1: clint_clk cycles per mtime increment (1-256).

Ports:
- clint_clk  in  1  clock; all state is updated on its rising edge.
- cpurst_b  in  1  reset, asynchronous, active-low.
- busif_regs_write_vld  in  1  write strobe, one cycle.
- busif_regs_read_vld  in  1  read strobe, one cycle.
- busif_regs_addr  in  16  byte offset within the CLINT space; bits [1:0] are ignored.
- busif_regs_wdata  in  32  write data.
- cpu_clint_mode  in  2  privilege mode of the requester; 2'b11 means M-mode.
- clint_time_en  in  1  mtime count enable.
- sysio_clint_me_int  in  HART_NUM  external interrupt per hart.
- regs_busif_rdata  out  32  read data, registered.
- regs_busif_rvld  out  1  read-data valid, registered.
- regs_busif_err  out  1  access error pulse, registered.
- clint_cpu_ms_int  out  HART_NUM  software interrupt per hart.
- clint_cpu_mt_int  out  HART_NUM  timer interrupt per hart.
- clint_cpu_me_int  out  HART_NUM  external interrupt per hart.
- clint_mtime  out  64  current mtime value.

## Operation
Address map (h = hart index):
- MSIP[h] at 0x0000+4h. Only bit 0 is stored; reads return {31'b0, msip[h]}.
- MTIMECMP[h] lo at 0x4000+8h, hi at 0x4004+8h.
- MTIME lo at 0xBFF8, hi at 0xBFFC.
- Any other offset, including a hart index ≥ HART_NUM, is unmapped.

Access rules:
- An access is legal only when cpu_clint_mode==2'b11 and the offset is mapped.
- An illegal write is dropped. An illegal read returns rdata=0.
- Either illegal case pulses regs_busif_err for one cycle, aligned with rvld for reads and one cycle after the strobe for writes.

mtime:
- Prescaler counter of width clog2(TICK_DIV), minimum 1.
- While clint_time_en=1 the prescaler counts 0..TICK_DIV-1. On the cycle it equals TICK_DIV-1 it returns to 0 and mtime increments by 1.
- When clint_time_en=0, both the prescaler and mtime hold.
- mtime wraps from 2^64-1 to 0.
- A legal write to MTIME lo or hi replaces that half with wdata. Any increment in that cycle is suppressed, so no carry propagates into or out of the written half. The prescaler is unaffected.

Interrupts:
- clint_cpu_mt_int[h] <= (mtime >= {mtimecmp_hi[h], mtimecmp_lo[h]}), an unsigned 64-bit compare registered from current register values.
- clint_cpu_ms_int[h] = msip[h], taken directly from the register.
- clint_cpu_me_int is a combinational pass-through of sysio_clint_me_int.

Bus conflicts:
- Read and write strobes in the same cycle: the write takes effect and the read returns the pre-write value.
- The bus guarantees at most one strobe of each type per cycle.

## Timing
Reset values:
- mtime=0, prescaler=0, msip=0, mtimecmp lo/hi=32'hffffffff.
- regs_busif_rdata=0, rvld=0, err=0, mt_int=0.
- clint_mtime=0 and ms_int=0 follow from the register resets; me_int follows its input.

Latencies:
- Read: strobe in cycle N, so rdata, rvld and err are valid in cycle N+1 for exactly one cycle.
- Write: register updates at the end of cycle N and is visible to a read strobed in N+1.
- msip write: ms_int changes in N+1.
- mtimecmp or mtime write: mt_int reflects the new value in N+2 (one cycle of register update, one cycle of compare register).
- mtime increment: clint_mtime changes in the cycle after the prescaler wrap; mt_int follows one cycle later.
- Asserting cpurst_b mid-operation clears all state immediately. A pending read produces no rvld.

## Test plan
- Reset, then read MTIMECMP[0] lo at 0x4000 in M-mode: rdata=32'hffffffff, rvld=1 exactly one cycle later, mt_int=0.
- TICK_DIV=4, clint_time_en=1 for 40 cycles: clint_mtime=10. Drop en for 8 cycles: mtime holds at 10.
- Write MTIME lo=32'hffffffff, hi=0; wait one tick: mtime=64'h1_00000000. Write hi=32'hffffffff, lo=32'hffffffff; wait one tick: mtime wraps to 0.
- Write MTIMECMP[2]={0,20} with mtime=18 and TICK_DIV=1: mt_int[2] rises exactly when clint_mtime reaches 20 (one cycle later); other harts stay 0. Write cmp=32'hffffffff: mt_int[2] falls 2 cycles later.
- S-mode (mode=2'b01) write 1 to MSIP[1]: err=1 one cycle later, ms_int[1] stays 0. Repeat in M-mode: ms_int[1]=1 next cycle; read of 0x0004 returns 1.
- HART_NUM=4, M-mode read of 0x0010 (MSIP[4]): rdata=0, err=1, rvld=1.

Source files
------------

// File: rtl/pa_clint_regs_mh.sv
// pa_clint_regs_mh: multi-hart CLINT register file with a local 64-bit mtime
// counter. It holds per-hart MSIP/MTIMECMP registers, answers decoded bus
// reads/writes with one cycle of latency and raises per-hart interrupts.
module pa_clint_regs_mh #(
  parameter int HART_NUM = 4,
  parameter int TICK_DIV = 1
) (
  input  logic                clint_clk,
  input  logic                cpurst_b,
  input  logic                busif_regs_write_vld,
  input  logic                busif_regs_read_vld,
  input  logic [15:0]         busif_regs_addr,
  input  logic [31:0]         busif_regs_wdata,
  input  logic [1:0]          cpu_clint_mode,
  input  logic                clint_time_en,
  input  logic [HART_NUM-1:0] sysio_clint_me_int,
  output logic [31:0]         regs_busif_rdata,
  output logic                regs_busif_rvld,
  output logic                regs_busif_err,
  output logic [HART_NUM-1:0] clint_cpu_ms_int,
  output logic [HART_NUM-1:0] clint_cpu_mt_int,
  output logic [HART_NUM-1:0] clint_cpu_me_int,
  output logic [63:0]         clint_mtime
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [15:0] MTIME_LO_OFF = 16'hbff8;
  localparam logic [15:0] MTIME_HI_OFF = 16'hbffc;

  logic [PW-1:0]       presc;
  logic [63:0]         mtime;
  logic [HART_NUM-1:0] msip;
  logic [31:0]         cmp_lo [HART_NUM];
  logic [31:0]         cmp_hi [HART_NUM];

  logic [15:0]         off;
  logic [HART_NUM-1:0] msip_sel;
  logic [HART_NUM-1:0] cmplo_sel;
  logic [HART_NUM-1:0] cmphi_sel;
  logic                mtlo_sel;
  logic                mthi_sel;
  logic                mapped;
  logic                legal;
  logic                wr_ok;
  logic                tick;
  logic [31:0]         rd_mux;

  // Word-aligned offset: the two byte-lane bits never take part in decode.
  assign off = busif_regs_addr & 16'hfffc;

  // Address decode into one-hot selects per register.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    msip_sel  = '0;
    cmplo_sel = '0;
    cmphi_sel = '0;
    for (int h = 0; h < HART_NUM; h++) begin
      msip_sel[h]  = (off == 16'(4 * h));
      cmplo_sel[h] = (off == 16'(16'h4000 + 8 * h));
      cmphi_sel[h] = (off == 16'(16'h4004 + 8 * h));
    end
  end

  assign mtlo_sel = (off == MTIME_LO_OFF);
  assign mthi_sel = (off == MTIME_HI_OFF);
  assign mapped   = (|msip_sel) | (|cmplo_sel) | (|cmphi_sel) | mtlo_sel | mthi_sel;
  assign legal    = (cpu_clint_mode == 2'b11) && mapped;
  assign wr_ok    = busif_regs_write_vld && legal;
  assign tick     = clint_time_en && (presc == PRESC_MAX);

  // Read mux over current (pre-write) register values.
  always_comb begin
    rd_mux = '0;
    for (int h = 0; h < HART_NUM; h++) begin
      if (msip_sel[h])  rd_mux = {31'b0, msip[h]};
      if (cmplo_sel[h]) rd_mux = cmp_lo[h];
      if (cmphi_sel[h]) rd_mux = cmp_hi[h];
    end
    if (mtlo_sel) rd_mux = mtime[31:0];
    if (mthi_sel) rd_mux = mtime[63:32];
  end

  // Prescaler and mtime; a bus write to either half overrides that cycle's tick.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clint_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      presc <= '0;
      mtime <= '0;
    end else begin
      if (clint_time_en) presc <= tick ? '0 : presc + 1'b1;
      if (wr_ok && mtlo_sel)      mtime[31:0]  <= busif_regs_wdata;
      else if (wr_ok && mthi_sel) mtime[63:32] <= busif_regs_wdata;
      else if (tick)              mtime        <= mtime + 64'd1;
    end
  end

  // Per-hart MSIP and MTIMECMP registers.
  // NOTE: the compare arrays are reset explicitly because all-ones is an architectural reset value, not a don't-care.
  always_ff @(posedge clint_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      msip <= '0;
      for (int h = 0; h < HART_NUM; h++) begin
        cmp_lo[h] <= 32'hffff_ffff;
        cmp_hi[h] <= 32'hffff_ffff;
      end
    end else if (wr_ok) begin
      for (int h = 0; h < HART_NUM; h++) begin
        if (msip_sel[h])  msip[h]   <= busif_regs_wdata[0];
        if (cmplo_sel[h]) cmp_lo[h] <= busif_regs_wdata;
        if (cmphi_sel[h]) cmp_hi[h] <= busif_regs_wdata;
      end
    end
  end

  // Registered timer-interrupt compare per hart.
  always_ff @(posedge clint_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      clint_cpu_mt_int <= '0;
    end else begin
      for (int h = 0; h < HART_NUM; h++) begin
        clint_cpu_mt_int[h] <= (mtime >= {cmp_hi[h], cmp_lo[h]});
      end
    end
  end

  // Registered bus response: read data/valid and the access-error pulse.
  always_ff @(posedge clint_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      regs_busif_rdata <= '0;
      regs_busif_rvld  <= 1'b0;
      regs_busif_err   <= 1'b0;
    end else begin
      regs_busif_rvld  <= busif_regs_read_vld;
      regs_busif_rdata <= (busif_regs_read_vld && legal) ? rd_mux : '0;
      regs_busif_err   <= (busif_regs_read_vld || busif_regs_write_vld) && !legal;
    end
  end

  assign clint_mtime      = mtime;
  assign clint_cpu_ms_int = msip;
  assign clint_cpu_me_int = sysio_clint_me_int;

endmodule
